down_counter_sync: RTL and testbench



---
 rtl/down_counter_sync_pkg.sv | 15 +
 rtl/down_counter_sync_if.sv | 21 ++
 rtl/down_counter_sync.sv | 40 ++++
 tb/tb_down_counter_sync.sv | 135 +++++++++++++
 4 files changed

// File: rtl/down_counter_sync_pkg.sv
//------------------------------------------------------------------------------
// Module  : down_counter_sync_pkg
// Brief   : Shared constants for the free-running down counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package down_counter_sync_pkg;

  localparam int c_DEFAULT_WIDTH = 4;
  localparam int c_MAX_WIDTH     = 32;

endpackage : down_counter_sync_pkg

`default_nettype wire

// File: rtl/down_counter_sync_if.sv
//------------------------------------------------------------------------------
// Module  : down_counter_sync_if
// Brief   : Count-value bus from the down counter to its consumers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface down_counter_sync_if
  import down_counter_sync_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] q;

  modport master (output q);
  modport slave  (input  q);

endinterface : down_counter_sync_if

`default_nettype wire

// File: rtl/down_counter_sync.sv
//------------------------------------------------------------------------------
// Module  : down_counter_sync
// Brief   : Free-running binary down counter, synchronous active-high reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module down_counter_sync
  import down_counter_sync_pkg::*;
#(
  parameter int               WIDTH       = c_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
)(
  input  wire logic             clk,
  input  wire logic             reset,
  down_counter_sync_if.master   cnt
);

  generate
    if (WIDTH < 1 || WIDTH > c_MAX_WIDTH) begin : g_bad_width
      $error("down_counter_sync: WIDTH must be in 1..32");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;

  // Borrow out of the subtraction is dropped, giving the 0 -> all-ones wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RESET_VALUE;
    end else begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign cnt.q = r_count;

endmodule : down_counter_sync

`default_nettype wire

// File: tb/tb_down_counter_sync.sv
//------------------------------------------------------------------------------
// Module  : tb_down_counter_sync
// Brief   : Self-checking bench for down_counter_sync at WIDTH=4 and WIDTH=3.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_down_counter_sync;

  typedef struct {
    logic       rst;
    logic [3:0] e4;
    logic [2:0] e3;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] e4;
    logic [2:0] e3;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sbq[$];
  logic [3:0] m4;
  logic [2:0] m3;

  down_counter_sync_if #(.WIDTH(4)) bus4 ();
  down_counter_sync_if #(.WIDTH(3)) bus3 ();

  down_counter_sync #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .cnt(bus4));
  down_counter_sync #(.WIDTH(3)) dut3 (.clk(clk), .reset(reset), .cnt(bus3));

  // First rising edge at 10 ns, period 20 ns.
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive reset, queue the expected result, clock once, then compare.
  task automatic step(input logic r, input logic [3:0] e4, input logic [2:0] e3, input string name);
    exp_t e;
    reset = r;
    sbq.push_back('{name, e4, e3});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({e.name, "_w4"}, 32'(bus4.q), 32'(e.e4));
    check({e.name, "_w3"}, 32'(bus3.q), 32'(e.e3));
    m4 = e4;
    m3 = e3;
  endtask

  task automatic count_step(input string name);
    step(1'b0, m4 - 4'd1, m3 - 3'd1, name);
  endtask

  initial begin
    vec_t       tbl[12];
    logic [3:0] q_before;

    tbl[0]  = '{1'b1, 4'd15, 3'd7};
    tbl[1]  = '{1'b1, 4'd15, 3'd7};
    tbl[2]  = '{1'b0, 4'd14, 3'd6};
    tbl[3]  = '{1'b0, 4'd13, 3'd5};
    tbl[4]  = '{1'b0, 4'd12, 3'd4};
    tbl[5]  = '{1'b0, 4'd11, 3'd3};
    tbl[6]  = '{1'b0, 4'd10, 3'd2};
    tbl[7]  = '{1'b0, 4'd9,  3'd1};
    tbl[8]  = '{1'b0, 4'd8,  3'd0};
    tbl[9]  = '{1'b0, 4'd7,  3'd7};
    tbl[10] = '{1'b0, 4'd6,  3'd6};
    tbl[11] = '{1'b0, 4'd5,  3'd5};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].e4, tbl[i].e3, $sformatf("table%0d", i));
    end

    // Count down through 0 and wrap; the full period is 16 edges.
    q_before = m4;
    for (int i = 0; i < 5; i++) count_step("to_zero");
    check("reached_zero", 32'(bus4.q), 32'd0);
    step(1'b0, 4'd15, m3 - 3'd1, "wrap_to_15");
    step(1'b0, 4'd14, m3 - 3'd1, "wrap_to_14");
    for (int i = 0; i < 9; i++) count_step("period");
    check("period_16", 32'(bus4.q), 32'(q_before));

    // Mid-count reset at q=7 reloads with no intermediate value.
    for (int i = 0; i < 16 && m4 != 4'd7; i++) count_step("seek7");
    check("at_seven", 32'(bus4.q), 32'd7);
    step(1'b1, 4'd15, 3'd7, "midcount_reset");
    step(1'b0, 4'd14, 3'd6, "release_after_mid");

    // Reset pulse entirely between edges must be ignored.
    #4 reset = 1'b1;
    #4 reset = 1'b0;
    check("glitch_no_async", 32'(bus4.q), 32'd14);
    step(1'b0, 4'd13, 3'd5, "glitch_ignored");

    // Reset raised just after an edge only acts at the following edge.
    reset = 1'b1;
    #5;
    check("late_reset_hold", 32'(bus4.q), 32'd13);
    step(1'b1, 4'd15, 3'd7, "late_reset_edge");
    step(1'b0, 4'd14, 3'd6, "late_release");

    // WIDTH=3 full period of 8 from reset.
    step(1'b1, 4'd15, 3'd7, "w3_reset");
    for (int i = 0; i < 8; i++) count_step("w3_cycle");
    check("w3_period_8", 32'(bus3.q), 32'd7);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_down_counter_sync

`default_nettype wire
